// File: rtl/ppu_post_quant_pipe.sv
// Two-stage requantiser that turns signed accumulators into unsigned activations with shift, round, relu, zero point and clamp.
// Latency is 2 cycles at 1 beat/cycle. in_ready is combinational from out_ready with no skid, and drops only when both stages hold data and out_ready is low.
module ppu_post_quant_pipe #(
   parameter int LANES   = 4,
   parameter int IN_W    = 32,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 6,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SHIFT_W-1:0]       cfg_shift,
   input  logic [OUT_W-1:0]         cfg_zp,
   input  logic                     cfg_round,
   input  logic                     cfg_relu,
   input  logic                     sat_clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*IN_W-1:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data,
   output logic [CNT_W-1:0]         sat_cnt
);

   localparam int YW  = IN_W + 1;
   localparam int ZW  = IN_W + 2;
   localparam int CW1 = CNT_W + 1;
   localparam logic [SHIFT_W-1:0]   SHIFT_MAX = SHIFT_W'(IN_W - 1);
   localparam logic signed [ZW-1:0] OUT_MAX   = ZW'(2**OUT_W - 1);
   localparam logic [CW1-1:0]       CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

   logic s1_adv, s2_adv, in_fire, out_fire;

   logic                         s1_vld_q;
   logic [LANES-1:0][YW-1:0]     s1_y_q, s1_y_d;
   logic [OUT_W-1:0]             s1_zp_q;

   logic                         s2_vld_q;
   logic [LANES*OUT_W-1:0]       s2_dat_q, s2_dat_d;
   logic [LANES-1:0]             s2_sat_q, s2_sat_d;

   logic [CNT_W-1:0]             sat_cnt_q, sat_cnt_d;

   assign s2_adv   = !s2_vld_q || out_ready;
   assign s1_adv   = !s1_vld_q || s2_adv;
   assign in_ready = s1_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_vld_q && out_ready;

   assign out_valid = s2_vld_q;
   assign out_data  = s2_dat_q;
   assign sat_cnt   = sat_cnt_q;

   // One extra bit of headroom lets +max round up without wrapping negative.
   always_comb begin
      logic [SHIFT_W-1:0]   sh;
      logic signed [YW-1:0] half;
      logic signed [YW-1:0] x;
      logic signed [YW-1:0] y;
      sh   = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
      half = '0;
      if (cfg_round && (sh != '0)) begin
         half = YW'(1) << (sh - SHIFT_W'(1));
      end
      s1_y_d = '0;
      for (int i = 0; i < LANES; i++) begin
         x = YW'($signed(in_data[i*IN_W +: IN_W]));
         y = (x + half) >>> sh;
         if (cfg_relu && (y < 0)) begin
            y = '0;
         end
         s1_y_d[i] = y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_y_q   <= '0;
         s1_zp_q  <= '0;
      end else if (s1_adv) begin
         s1_vld_q <= in_valid;
         if (in_fire) begin
            s1_y_q  <= s1_y_d;
            s1_zp_q <= cfg_zp;
         end
      end
   end

   always_comb begin
      logic signed [ZW-1:0] z;
      s2_dat_d = '0;
      s2_sat_d = '0;
      for (int i = 0; i < LANES; i++) begin
         z = ZW'($signed(s1_y_q[i])) + ZW'($signed({1'b0, s1_zp_q}));
         if (z < 0) begin
            s2_dat_d[i*OUT_W +: OUT_W] = '0;
            s2_sat_d[i]                = 1'b1;
         end else if (z > OUT_MAX) begin
            s2_dat_d[i*OUT_W +: OUT_W] = '1;
            s2_sat_d[i]                = 1'b1;
         end else begin
            s2_dat_d[i*OUT_W +: OUT_W] = z[OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
         s2_dat_q <= '0;
         s2_sat_q <= '0;
      end else if (s2_adv) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_dat_q <= s2_dat_d;
            s2_sat_q <= s2_sat_d;
         end
      end
   end

   // Clear wins over a same-cycle delivery; the count sticks at all-ones.
   always_comb begin
      logic [CW1-1:0] sum;
      sum       = {1'b0, sat_cnt_q} + CW1'($countones(s2_sat_q));
      sat_cnt_d = sat_cnt_q;
      if (sat_clr) begin
         sat_cnt_d = '0;
      end else if (out_fire) begin
         sat_cnt_d = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

endmodule

// File: tb/tb_ppu_post_quant_pipe.sv
// Bench for ppu_post_quant_pipe: directed beats with literal expectations plus an arithmetic scoreboard
// that checks data, ordering, in_ready, stall stability and the saturation counter on every cycle.
module tb_ppu_post_quant_pipe;

   localparam int LANES   = 4;
   localparam int IN_W    = 32;
   localparam int OUT_W   = 8;
   localparam int SHIFT_W = 6;
   localparam int CNT_W   = 4;
   localparam int CNT_TOP = 15;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [SHIFT_W-1:0]     cfg_shift;
   logic [OUT_W-1:0]       cfg_zp;
   logic                   cfg_round, cfg_relu, sat_clr;
   logic                   in_valid, in_ready;
   logic [LANES*IN_W-1:0]  in_data;
   logic                   out_valid, out_ready;
   logic [LANES*OUT_W-1:0] out_data;
   logic [CNT_W-1:0]       sat_cnt;

   ppu_post_quant_pipe #(
      .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
      .cfg_round(cfg_round), .cfg_relu(cfg_relu), .sat_clr(sat_clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dat;
      int          nsat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_out = 0;
   int          model_cnt = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_data = '0;
   bit          bp_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   // Per-lane arithmetic straight from the rules, using 64-bit integers and floor division.
   function automatic exp_t model_beat(input logic [127:0] d, input logic [5:0] sh,
                                       input logic [7:0] zp, input logic rnd, input logic relu);
      exp_t   e;
      int     s;
      longint x, p, y, z;
      e.dat  = '0;
      e.nsat = 0;
      s = (int'(sh) > IN_W - 1) ? IN_W - 1 : int'(sh);
      p = longint'(1) << s;
      for (int i = 0; i < LANES; i++) begin
         x = longint'($signed(d[i*IN_W +: IN_W]));
         if (rnd && s > 0) x = x + p / 2;
         y = (x >= 0) ? x / p : -((-x + p - 1) / p);
         if (relu && y < 0) y = 0;
         z = y + longint'(zp);
         if (z < 0) begin
            e.nsat++;
         end else if (z > 255) begin
            e.dat[i*8 +: 8] = 8'hFF;
            e.nsat++;
         end else begin
            e.dat[i*8 +: 8] = z[7:0];
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         model_cnt  = 0;
         prev_stall = 0;
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_out_data", 64'(out_data), 64'(0));
         chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
      end else begin
         chk("in_ready_occupancy", 64'(in_ready), 64'(!(sb.size() == 2 && !out_ready)));
         if (sb.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'(0));
         if (prev_stall) begin
            chk("stall_valid_held", 64'(out_valid), 64'(1));
            chk("stall_data_held", 64'(out_data), 64'(prev_data));
         end
         chk("sat_cnt_model", 64'(sat_cnt), 64'(model_cnt));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_beat: got 0x%0h, expected no beat", out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("beat_data", 64'(out_data), 64'(e.dat));
               n_out++;
               if (!sat_clr) model_cnt = (model_cnt + e.nsat > CNT_TOP) ? CNT_TOP : model_cnt + e.nsat;
            end
         end
         if (sat_clr) model_cnt = 0;
         if (in_valid && in_ready) sb.push_back(model_beat(in_data, cfg_shift, cfg_zp, cfg_round, cfg_relu));
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic drive_beat(input int l0, input int l1, input int l2, input int l3,
                             input int sh, input int zp, input logic rnd, input logic relu);
      bit ok = 0;
      in_data   = {l3, l2, l1, l0};
      cfg_shift = SHIFT_W'(sh);
      cfg_zp    = OUT_W'(zp);
      cfg_round = rnd;
      cfg_relu  = relu;
      in_valid  = 1'b1;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) fail_to("in_handshake");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [31:0] exp);
      bit seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            seen = 1;
            chk(name, 64'(out_data), 64'(exp));
         end
      end
      if (!seen) fail_to(name);
   endtask

   task automatic chk_sat(input string name, input int exp);
      @(posedge clk);
      #1;
      chk(name, 64'(sat_cnt), 64'(exp));
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         done = (sb.size() == 0);
      end
      if (!done) fail_to(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_shift = '0; cfg_zp = '0;
      cfg_round = 1'b0; cfg_relu = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      drive_beat(160, -32, -2048, 4096, 4, 128, 1'b0, 1'b0);
      expect_out("t1_legacy", {8'd255, 8'd0, 8'd126, 8'd138});
      chk_sat("t1_sat_cnt", 1);

      drive_beat(5, 6, -6, -7, 2, 0, 1'b1, 1'b0);
      expect_out("t2_round", {8'd0, 8'd0, 8'd2, 8'd1});
      chk_sat("t2_round_sat", 3);
      drive_beat(5, 6, -6, -7, 2, 0, 1'b0, 1'b0);
      expect_out("t2_trunc", {8'd0, 8'd0, 8'd1, 8'd1});
      chk_sat("t2_trunc_sat", 5);

      drive_beat(-100, 50, 0, 127, 0, 128, 1'b0, 1'b1);
      expect_out("t3_relu", {8'd255, 8'd128, 8'd178, 8'd128});
      chk_sat("t3_relu_sat", 5);

      drive_beat(32'h7FFFFFFF, 32'h80000000, 0, 1, 0, 128, 1'b1, 1'b0);
      expect_out("t5_extremes", {8'd129, 8'd128, 8'd0, 8'd255});
      chk_sat("t5_extremes_sat", 7);
      drive_beat(32'h80000000, 32'h7FFFFFFF, -1, 0, 63, 128, 1'b1, 1'b0);
      expect_out("t5_shift63", {8'd128, 8'd128, 8'd129, 8'd127});
      drive_beat(32'h7FFFFFFF, 32'h40000000, 32'h3FFFFFFF, 32'hC0000000, 31, 0, 1'b1, 1'b0);
      expect_out("t5_round_nowrap", {8'd0, 8'd0, 8'd1, 8'd1});
      chk_sat("t5_nosat", 7);
      for (int b = 0; b < 3; b++) begin
         drive_beat(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 128, 1'b0, 1'b0);
         expect_out("t5_sat_beat", 32'hFFFFFFFF);
         chk_sat("t5_sat_climb", (b == 0) ? 11 : 15);
      end
      drive_beat(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 128, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      chk("t5_clr_beat_delivered", 64'(out_valid), 64'(0));
      chk("t5_clr_priority", 64'(sat_cnt), 64'(0));

      n0 = n_out;
      bp_en = 1;
      fork
         begin
            while (bp_en) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join_none
      for (int b = 0; b < 8; b++) begin
         drive_beat(b * 1000 - 3000, -b * 777, 32'h7FFFFFFF - b, b << 20,
                    (b % 5) + ((b == 3) ? 40 : 0), b * 30, 1'((b % 2) == 1), 1'((b / 2) % 2 == 1));
      end
      bp_en = 0;
      drain("t4_drain");
      repeat (3) @(posedge clk);
      #1;
      chk("t4_beats_out", 64'(n_out - n0), 64'(8));

      drive_beat(32'h7FFFFFFF, 1, 2, 3, 0, 128, 1'b0, 1'b0);
      expect_out("t6_pre_beat", {8'd131, 8'd130, 8'd129, 8'd255});
      @(posedge clk);
      #1;
      chk("t6_pre_sat_nonzero", 64'(sat_cnt != '0), 64'(1));
      out_ready = 1'b0;
      drive_beat(32'h7FFFFFFF, 1, 2, 3, 0, 128, 1'b0, 1'b0);
      drive_beat(4, 5, 6, 7, 0, 0, 1'b0, 1'b0);
      chk("t6_full_in_ready", 64'(in_ready), 64'(0));
      chk("t6_full_out_valid", 64'(out_valid), 64'(1));
      rst = 1'b1;
      #1;
      chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
      chk("t6_rst_sat_cnt", 64'(sat_cnt), 64'(0));
      chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      drive_beat(100, 200, 300, -300, 1, 10, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_lat_cycle1", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("t6_lat_cycle2", 64'(out_valid), 64'(1));
      chk("t6_post_rst_beat", 64'(out_data), 64'({8'd0, 8'd160, 8'd110, 8'd60}));
      drain("t6_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
